// File: rtl/sccb_target.sv
// SCCB / I2C register target.
// Oversamples sioc/siod on clk, decodes START/STOP and bit edges, and bridges
// 3-phase writes (ID, register, data...) and 2-phase reads onto an 8-bit
// register port. siod is open-drain: the pad logic pulls low while siod_oe=1.
module sccb_target #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       reg_re,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RD_ACK    = 4'd8
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_p_q, scl_p_d;
    logic                   sda_p_q, sda_p_d;
    logic [3:0]             cnt_q, cnt_d;     // bit counter within a byte
    logic [6:0]             sh_q, sh_d;       // receive shifter (first 7 bits)
    logic [7:0]             tx_q, tx_d;       // transmit shifter, MSB goes out next
    logic [7:0]             ptr_q, ptr_d;     // register pointer
    logic [7:0]             wdata_q, wdata_d;
    logic                   oe_q, oe_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   busy_q, busy_d;
    logic                   rw_q, rw_d;       // R/W bit of the last matching ID

    logic                   scl_s, sda_s;
    logic                   scl_rise_s, scl_fall_s;
    logic                   start_s, stop_s;
    logic [7:0]             byte_s;
    logic                   last_bit_s;
    logic                   id_match_s;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_p_q;
    assign scl_fall_s = ~scl_s & scl_p_q;
    // SDA edges only count as bus conditions while SCL is stably high
    assign start_s    = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_s     = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign byte_s     = {sh_q, sda_s};
    assign last_bit_s = (cnt_q == 4'd7);
    assign id_match_s = (byte_s[7:1] == DEV_ID[7:1]);

    // Synchronizer shift and edge-detect history.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], sioc};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], siod_i};
        scl_p_d    = scl_s;
        sda_p_d    = sda_s;
    end

    // All state flops; reset releases siod immediately and idles the bus view high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            cnt_q      <= 4'd0;
            sh_q       <= 7'd0;
            tx_q       <= 8'd0;
            ptr_q      <= 8'd0;
            wdata_q    <= 8'd0;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    // Next-state: bus conditions first, then byte/ACK sequencing.
    always_comb begin
        state_d = state_q;
        if (stop_s) begin
            state_d = ST_IDLE;
        end else if (start_s) begin
            state_d = ST_DEV;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DEV: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_d = id_match_s ? ST_DEV_ACK : ST_IDLE;
                    end else begin
                        state_d = ST_DEV;
                    end
                end
                ST_DEV_ACK: begin
                    // oe_q set means the ACK is already on the bus; this fall ends it
                    if (scl_fall_s && oe_q) begin
                        state_d = rw_q ? ST_RDATA : ST_REG;
                    end else begin
                        state_d = ST_DEV_ACK;
                    end
                end
                ST_REG: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_d = ST_REG_ACK;
                    end else begin
                        state_d = ST_REG;
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall_s && oe_q) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_REG_ACK;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_d = ST_WDATA_ACK;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall_s && oe_q) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (!re_q && scl_fall_s && (cnt_q == 4'd8)) begin
                        state_d = ST_RD_ACK;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s && sda_s) begin
                        state_d = ST_IDLE;
                    end else if (scl_fall_s && (cnt_q == 4'd1)) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_RD_ACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs for each state.
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        oe_d    = oe_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        busy_d  = busy_q;
        rw_d    = rw_q;
        if (stop_s) begin
            cnt_d  = 4'd0;
            oe_d   = 1'b0;
            busy_d = 1'b0;
        end else if (start_s) begin
            cnt_d = 4'd0;
            oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_REG, ST_WDATA: begin
                    if (scl_rise_s) begin
                        sh_d = byte_s[6:0];
                        if (last_bit_s) begin
                            cnt_d = 4'd0;
                            if (state_q == ST_DEV) begin
                                busy_d = id_match_s;
                                rw_d   = byte_s[0];
                            end else if (state_q == ST_REG) begin
                                ptr_d = byte_s;
                            end else begin
                                wdata_d = byte_s;
                                we_d    = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        sh_d = sh_q;
                    end
                end
                ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if ((state_q == ST_DEV_ACK) && rw_q) begin
                                // keep the bus held until the first read bit is loaded
                                re_d = 1'b1;
                            end else begin
                                oe_d = 1'b0;
                                if (state_q == ST_WDATA_ACK) begin
                                    ptr_d = ptr_q + 8'd1;
                                end else begin
                                    ptr_d = ptr_q;
                                end
                            end
                        end
                    end else begin
                        oe_d = oe_q;
                    end
                end
                ST_RDATA: begin
                    if (re_q) begin
                        // reg_rdata is valid for the current pointer in the strobe cycle
                        tx_d  = {reg_rdata[6:0], 1'b0};
                        oe_d  = ~reg_rdata[7];
                        cnt_d = 4'd1;
                    end else if (scl_fall_s) begin
                        if (cnt_q == 4'd8) begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                        end else begin
                            oe_d  = ~tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        tx_d = tx_q;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s) begin
                            busy_d = 1'b0;
                            cnt_d  = 4'd0;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall_s && (cnt_q == 4'd1)) begin
                        re_d  = 1'b1;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    cnt_d = 4'd0;
                    oe_d  = 1'b0;
                end
            endcase
        end
    end

    assign siod_oe   = oe_q;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master, a bench-side register file
// behind the register port, and a transaction-level reference model
// (pointer + memory image) that predicts ACKs, writes and read data.
module tb_sccb_target;

    localparam int Q = 6;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sioc;
    logic       msda;      // master drive: 1 = release
    logic       siod_w;
    logic       siod_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       reg_re;
    logic       busy;

    always #5 clk = ~clk;

    assign siod_w = (siod_oe || !msda) ? 1'b0 : 1'b1;

    sccb_target #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sioc(sioc), .siod_i(siod_w), .siod_oe(siod_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .reg_re(reg_re), .busy(busy)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h0A) ? 8'h76 : (a ^ 8'h5A);
    endfunction

    logic [7:0]  env_mem [256];
    logic        mem_init = 1'b0;
    logic [15:0] we_log [$];
    int          re_cnt = 0;
    int          viol = 0;
    logic        oe_prev = 1'b0;
    logic        rst_prev = 1'b0;

    assign reg_rdata = env_mem[reg_addr];

    // Bench register file plus strobe and bus-discipline monitors.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(8'(i));
            mem_init <= 1'b1;
        end else if (rst_n && reg_we) begin
            env_mem[reg_addr] <= reg_wdata;
        end
        if (rst_n && reg_we) we_log.push_back({reg_addr, reg_wdata});
        if (rst_n && reg_re) re_cnt <= re_cnt + 1;
        if (rst_n && rst_prev && sioc && (siod_oe !== oe_prev)) viol <= viol + 1;
        oe_prev  <= siod_oe;
        rst_prev <= rst_n;
    end

    int          total = 0;
    int          bad = 0;
    logic [7:0]  model_mem [256];
    logic [7:0]  m_ptr;
    logic [15:0] exp_we [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tick(Q); msda = 1'b1; tick(Q); sioc = 1'b1; tick(Q); msda = 1'b0; tick(Q); sioc = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q); msda = 1'b0; tick(Q); sioc = 1'b1; tick(Q); msda = 1'b1; tick(Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        tick(Q); msda = b; tick(Q); sioc = 1'b1; tick(Q); s = siod_w; tick(Q); sioc = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    // Full write transaction followed by STOP, checked against the model.
    task automatic run_write(input string nm, input logic [7:0] id, input logic [7:0] rg,
                             input int nd, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, output int acks);
        logic       a;
        logic       match;
        logic [7:0] dv [3];
        int         we0;
        dv    = '{d0, d1, d2};
        match = (id[7:1] == 7'h21) && !id[0];
        we0   = we_log.size();
        acks  = 0;
        bus_start();
        put_byte(id, a); acks += int'(a);
        chk($sformatf("%s_busy_on", nm), 32'(busy), 32'(match));
        put_byte(rg, a); acks += int'(a);
        for (int i = 0; i < nd; i++) begin
            put_byte(dv[i], a); acks += int'(a);
        end
        bus_stop();
        tick(4);
        chk($sformatf("%s_busy_off", nm), 32'(busy), 32'd0);
        if (match) begin
            m_ptr = rg;
            for (int i = 0; i < nd; i++) begin
                exp_we.push_back({m_ptr, dv[i]});
                model_mem[m_ptr] = dv[i];
                m_ptr = m_ptr + 8'd1;
            end
        end
        chk($sformatf("%s_acks", nm), 32'(acks), match ? 32'(2 + nd) : 32'd0);
        chk($sformatf("%s_we_cnt", nm), 32'(we_log.size() - we0), match ? 32'(nd) : 32'd0);
        for (int k = we0; k < we_log.size() && k < exp_we.size(); k++)
            chk($sformatf("%s_we_%0d", nm, k), 32'(we_log[k]), 32'(exp_we[k]));
        chk($sformatf("%s_addr", nm), 32'(reg_addr), 32'(m_ptr));
    endtask

    // Read of n bytes (last one NACKed); pre >= 0 first sets the pointer and
    // uses a repeated START instead of a STOP.
    task automatic run_read(input string nm, input int n, input int pre, output logic [7:0] first);
        logic       a;
        logic [7:0] d;
        int         we0, re0;
        we0 = we_log.size();
        re0 = re_cnt;
        bus_start();
        if (pre >= 0) begin
            put_byte(8'h42, a); chk($sformatf("%s_pre_id_ack", nm), 32'(a), 32'd1);
            put_byte(8'(pre), a); chk($sformatf("%s_pre_reg_ack", nm), 32'(a), 32'd1);
            m_ptr = 8'(pre);
            bus_start();
        end
        put_byte(8'h43, a);
        chk($sformatf("%s_id_ack", nm), 32'(a), 32'd1);
        first = 8'h00;
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, d);
            if (i == 0) first = d;
            chk($sformatf("%s_rd%0d", nm, i), 32'(d), 32'(model_mem[m_ptr]));
            if (i < n - 1) m_ptr = m_ptr + 8'd1;
        end
        tick(Q);
        chk($sformatf("%s_oe_nack", nm), 32'(siod_oe), 32'd0);
        bus_stop();
        tick(4);
        chk($sformatf("%s_busy_off", nm), 32'(busy), 32'd0);
        chk($sformatf("%s_re_cnt", nm), 32'(re_cnt - re0), 32'(n));
        chk($sformatf("%s_no_we", nm), 32'(we_log.size() - we0), 32'd0);
        chk($sformatf("%s_addr", nm), 32'(reg_addr), 32'(m_ptr));
    endtask

    // Reset in the middle of a write: during the REG ACK hold, or during data bit 4.
    task automatic reset_mid(input string nm, input logic at_ack);
        logic       a, s;
        logic [7:0] rg;
        int         we0;
        rg  = 8'h0C;
        we0 = we_log.size();
        bus_start();
        put_byte(8'h42, a);
        if (at_ack) begin
            for (int i = 7; i >= 0; i--) bus_bit(rg[i], s);
            tick(Q); msda = 1'b1;
        end else begin
            put_byte(rg, a);
            bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
            tick(Q); msda = 1'b0;
        end
        tick(Q); sioc = 1'b1; tick(Q);
        chk($sformatf("%s_oe_before", nm), 32'(siod_oe), 32'(at_ack));
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s_oe_async", nm), 32'(siod_oe), 32'd0);
        tick(2);
        chk($sformatf("%s_addr_rst", nm), 32'(reg_addr), 32'd0);
        chk($sformatf("%s_busy_rst", nm), 32'(busy), 32'd0);
        msda = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(Q); sioc = 1'b0;
        bus_stop();
        tick(4);
        m_ptr = 8'h00;
        chk($sformatf("%s_no_we", nm), 32'(we_log.size() - we0), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  rg;
        int          nd;
        logic [7:0]  d0, d1, d2;
        int          exp_acks;
        int          exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_last;
    } wvec_t;

    initial begin
        wvec_t      tbl [3];
        int         acks, we0, kind, nd;
        logic [7:0] id, rg, first;

        tbl[0] = '{8'h42, 8'h12, 1, 8'h80, 8'h00, 8'h00, 3, 1, 8'h13, 16'h1280};
        tbl[1] = '{8'h60, 8'h12, 1, 8'h80, 8'h00, 8'h00, 0, 0, 8'h13, 16'h0000};
        tbl[2] = '{8'h42, 8'hFE, 3, 8'h11, 8'h22, 8'h33, 5, 3, 8'h01, 16'h0033};

        for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
        m_ptr = 8'h00;
        rst_n = 1'b0;
        sioc  = 1'b1;
        msda  = 1'b1;
        tick(5);
        chk("rst_oe", 32'(siod_oe), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_we", 32'(reg_we), 32'd0);
        chk("rst_re", 32'(reg_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(5);

        for (int t = 0; t < 3; t++) begin
            we0 = we_log.size();
            run_write($sformatf("tbl%0d", t), tbl[t].id, tbl[t].rg, tbl[t].nd,
                      tbl[t].d0, tbl[t].d1, tbl[t].d2, acks);
            chk($sformatf("tbl%0d_acks_k", t), 32'(acks), 32'(tbl[t].exp_acks));
            chk($sformatf("tbl%0d_we_k", t), 32'(we_log.size() - we0), 32'(tbl[t].exp_we));
            chk($sformatf("tbl%0d_addr_k", t), 32'(reg_addr), 32'(tbl[t].exp_addr));
            if (tbl[t].exp_we > 0 && we_log.size() > 0)
                chk($sformatf("tbl%0d_last_k", t), 32'(we_log[we_log.size() - 1]), 32'(tbl[t].exp_last));
        end

        run_write("ptr_set", 8'h42, 8'h0A, 0, 8'h00, 8'h00, 8'h00, acks);
        run_read("rd_76", 1, -1, first);
        chk("rd_76_k", 32'(first), 32'h76);
        run_read("rstart", 2, 8'h0A, first);
        chk("rstart_k", 32'(first), 32'h76);

        reset_mid("rst_ack", 1'b1);
        reset_mid("rst_wbit4", 1'b0);
        run_write("post_rst", 8'h42, 8'h0C, 1, 8'h5A, 8'h00, 8'h00, acks);

        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 2));
            rg   = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                nd = int'($urandom_range(1, 3));
                run_read($sformatf("rnd%0d_rd", t), nd, ($urandom_range(0, 1) == 1) ? int'(rg) : -1, first);
            end else begin
                id = 8'h42;
                if ($urandom_range(0, 4) == 0) begin
                    id = 8'($urandom_range(0, 255));
                    if (id[7:1] == 7'h21) id = 8'h60;
                end
                nd = int'($urandom_range(0, 3));
                run_write($sformatf("rnd%0d_wr", t), id, rg, nd, 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acks);
            end
        end

        chk("oe_stable_scl_high", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
